joybus_poll_ctrl: RTL

Transaction sequencer for the N64 Joybus link. It periodically issues a poll command through the Joybus transmitter, then arms `JOYBUS_rx` and waits for the reply. On success it latches the controller status and button data; if no reply arrives within a timeout it retries and eventually flags the pad absent. It sits between the serial PHY pair (tx/rx) and the console-side logic that consumes pad state.

---
 rtl/joybus_pkg.sv | 14 +
 rtl/joybus_poll_timer.sv | 31 +++
 rtl/joybus_poll_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/joybus_pkg.sv
// Shared Joybus definitions: poll FSM states and controller command bytes.
package joybus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TX_WAIT,
    RX_WAIT,
    GAP
  } jb_poll_state_t;

  localparam logic [7:0] JB_CMD_INFO = 8'h00;
  localparam logic [7:0] JB_CMD_POLL = 8'h01;

endpackage

// File: rtl/joybus_poll_timer.sv
// Periodic poll tick generator with a sticky overrun flag for ticks that
// land while a transaction is still in flight.
module joybus_poll_timer #(
  parameter int POLL_PERIOD = 416667
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic busy,
  output logic tick,
  output logic overrun
);

  localparam int PW = $clog2(POLL_PERIOD + 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == PW'(POLL_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      if (!en || tick) cnt <= '0;
      else             cnt <= cnt + PW'(1);
      if (tick && busy) overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/joybus_poll_ctrl.sv
// Joybus poll sequencer: send poll, await reply, retry on timeout,
// publish pad state to the console side.
module joybus_poll_ctrl
  import joybus_pkg::*;
#(
  parameter int POLL_PERIOD = 416667,
  parameter int RX_TIMEOUT  = 2500,
  parameter int GAP_CYCLES  = 100,
  parameter int RETRIES     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        poll_now,
  output logic        tx_start,
  output logic [7:0]  tx_cmd,
  input  logic        tx_done,
  output logic        jb_oe,
  output logic        rx_start,
  input  logic        rx_done,
  input  logic [7:0]  jb_cntlr_status,
  input  logic [15:0] jb_cntlr_data,
  output logic [7:0]  pad_status,
  output logic [15:0] pad_data,
  output logic        pad_valid,
  output logic        pad_present,
  output logic        err_timeout,
  output logic        overrun,
  output logic        busy
);

  localparam int CMAX = (RX_TIMEOUT > GAP_CYCLES) ? RX_TIMEOUT : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = $clog2(RETRIES + 2);

  jb_poll_state_t state, state_nx;

  logic [CW-1:0] cnt, cnt_nx;
  logic [RW-1:0] retry, retry_nx;
  logic          tick, trigger;
  logic          tx_start_nx, rx_start_nx;
  logic          pad_valid_nx, err_nx;
  logic          present_nx, latch;

  joybus_poll_timer #(
    .POLL_PERIOD(POLL_PERIOD)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .busy    (busy),
    .tick    (tick),
    .overrun (overrun)
  );

  assign trigger = tick || poll_now;
  assign busy    = (state != IDLE);
  assign jb_oe   = (state == TX_WAIT);
  assign tx_cmd  = JB_CMD_POLL;

  // cnt is shared: reply timeout in RX_WAIT, settle delay in GAP
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    retry_nx     = retry;
    tx_start_nx  = 1'b0;
    rx_start_nx  = 1'b0;
    pad_valid_nx = 1'b0;
    err_nx       = 1'b0;
    present_nx   = pad_present;
    latch        = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          state_nx    = TX_WAIT;
          tx_start_nx = 1'b1;
          retry_nx    = '0;
        end
      end
      TX_WAIT: begin
        if (tx_done) begin
          state_nx    = RX_WAIT;
          rx_start_nx = 1'b1;
          cnt_nx      = CW'(RX_TIMEOUT - 1);
        end
      end
      RX_WAIT: begin
        if (rx_done) begin
          state_nx     = IDLE;
          pad_valid_nx = 1'b1;
          present_nx   = 1'b1;
          latch        = 1'b1;
        end else if (cnt == '0) begin
          if (retry < RW'(RETRIES)) begin
            state_nx = GAP;
            retry_nx = retry + RW'(1);
            cnt_nx   = CW'(GAP_CYCLES - 1);
          end else begin
            state_nx   = IDLE;
            err_nx     = 1'b1;
            present_nx = 1'b0;
          end
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nx    = TX_WAIT;
          tx_start_nx = 1'b1;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      retry       <= '0;
      tx_start    <= 1'b0;
      rx_start    <= 1'b0;
      pad_valid   <= 1'b0;
      err_timeout <= 1'b0;
      pad_present <= 1'b0;
      pad_status  <= '0;
      pad_data    <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      retry       <= retry_nx;
      tx_start    <= tx_start_nx;
      rx_start    <= rx_start_nx;
      pad_valid   <= pad_valid_nx;
      err_timeout <= err_nx;
      pad_present <= present_nx;
      if (latch) begin
        pad_status <= jb_cntlr_status;
        pad_data   <= jb_cntlr_data;
      end
    end
  end

endmodule
